// File: rtl/seq_step_controller.sv
// -----------------------------------------------------------------------------
// seq_step_controller
//
// Command sequencer for the up/down digit-sequence machine (9-position ring
// plus Blank). Raw pushbuttons are synchronized and edge-detected, an optional
// auto-step timer produces periodic requests, and the two sources are
// arbitrated into clean single-cycle UP/DOWN commands with a hold-off gap
// between consecutive commands. A mirror of the machine position is kept
// locally so the top level can display or check it.
//
// Parameters:
//   SYNC_STAGES  synchronizer flops per raw button (>= 2)
//   TICK_DIV     auto-step period in clock cycles (>= 2)
//   HOLDOFF      idle cycles forced after every issued command (>= 1)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   btn_up    in   raw up button (asynchronous)
//   btn_down  in   raw down button (asynchronous)
//   auto_en   in   enable periodic auto-stepping (synchronous)
//   auto_dir  in   auto direction, 0 = up, 1 = down (synchronous)
//   up        out  UP command pulse (registered)
//   down      out  DOWN command pulse (registered); up & down = Blank
//   busy      out  controller is in ISSUE or HOLD (registered)
//   pos       out  position mirror: 0..8 ring index, 9 = Blank (registered)
// -----------------------------------------------------------------------------
`default_nettype none

module seq_step_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 25000000,
    parameter int HOLDOFF     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       auto_en,
    input  logic       auto_dir,
    output logic       up,
    output logic       down,
    output logic       busy,
    output logic [3:0] pos
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    // Command encoding is {up, down}; 2'b11 commands Blank.
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_DOWN  = 2'b01;
    localparam logic [1:0] CMD_UP    = 2'b10;
    localparam logic [1:0] CMD_BLANK = 2'b11;

    localparam logic [3:0] POS_LAST  = 4'd8;
    localparam logic [3:0] POS_BLANK = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Position the machine will hold after executing cmd from cur.
    function automatic logic [3:0] next_pos(input logic [3:0] cur, input logic [1:0] cmd);
        logic [3:0] res;
        case (cmd)
            CMD_UP: begin
                if (cur >= POS_LAST) begin
                    res = 4'd0;
                end else begin
                    res = cur + 4'd1;
                end
            end
            CMD_DOWN: begin
                if ((cur == 4'd0) || (cur >= POS_BLANK)) begin
                    res = POS_LAST;
                end else begin
                    res = cur - 4'd1;
                end
            end
            CMD_BLANK: res = POS_BLANK;
            default:   res = cur;
        endcase
        return res;
    endfunction

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_up_r;
    logic [SYNC_STAGES-1:0] sync_dn_r;
    logic                   last_up_r;
    logic                   last_dn_r;
    logic                   man_up_s;
    logic                   man_dn_s;

    logic [TICK_W-1:0]      tick_cnt_r;
    logic                   tick_hit_s;
    logic                   tick_s;

    logic                   req_man_s;
    logic [1:0]             req_cmd_s;

    logic                   pend_valid_r;
    logic                   pend_man_r;
    logic [1:0]             pend_cmd_r;

    logic                   mrg_valid_s;
    logic                   mrg_man_s;
    logic [1:0]             mrg_cmd_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic [HOLD_W-1:0]      hold_nxt_s;
    logic                   issue_go_s;
    logic                   pend_nxt_valid_s;
    logic                   pend_nxt_man_s;
    logic [1:0]             pend_nxt_cmd_s;

    logic                   up_r;
    logic                   down_r;
    logic                   busy_r;
    logic [3:0]             pos_r;

    // ---------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------

    // Button synchronizer chains plus previous value of the last stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_up_r <= '0;
            sync_dn_r <= '0;
            last_up_r <= 1'b0;
            last_dn_r <= 1'b0;
        end else begin
            sync_up_r <= {sync_up_r[SYNC_STAGES-2:0], btn_up};
            sync_dn_r <= {sync_dn_r[SYNC_STAGES-2:0], btn_down};
            last_up_r <= sync_up_r[SYNC_STAGES-1];
            last_dn_r <= sync_dn_r[SYNC_STAGES-1];
        end
    end

    // Only rising edges are requests; a button held steady never re-requests.
    assign man_up_s = sync_up_r[SYNC_STAGES-1] & ~last_up_r;
    assign man_dn_s = sync_dn_r[SYNC_STAGES-1] & ~last_dn_r;

    // ---------------------------------------------------------------------
    // Auto-step timer
    // ---------------------------------------------------------------------

    assign tick_hit_s = (tick_cnt_r == TICK_W'(TICK_DIV - 1));
    assign tick_s     = auto_en & tick_hit_s;

    // Free-running divider while enabled; held at zero when disabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= '0;
        end else if (!auto_en) begin
            tick_cnt_r <= '0;
        end else if (tick_hit_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Request arbitration
    // ---------------------------------------------------------------------

    // Any manual edge wins over a simultaneous tick, which is then discarded.
    assign req_man_s = man_up_s | man_dn_s;
    assign req_cmd_s = req_man_s ? {man_up_s, man_dn_s}
                                 : (auto_dir ? CMD_DOWN : CMD_UP);

    // Pending entry as it stands after folding in this cycle's request.
    // Manual overwrites anything; auto may only replace an empty or auto entry.
    always_comb begin
        mrg_valid_s = pend_valid_r;
        mrg_man_s   = pend_man_r;
        mrg_cmd_s   = pend_cmd_r;
        if (req_man_s) begin
            mrg_valid_s = 1'b1;
            mrg_man_s   = 1'b1;
            mrg_cmd_s   = req_cmd_s;
        end else if (tick_s && (!pend_valid_r || !pend_man_r)) begin
            mrg_valid_s = 1'b1;
            mrg_man_s   = 1'b0;
            mrg_cmd_s   = req_cmd_s;
        end else begin
            mrg_valid_s = pend_valid_r;
            mrg_man_s   = pend_man_r;
            mrg_cmd_s   = pend_cmd_r;
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------

    // Next-state logic. The merged entry is consumed whenever ISSUE is
    // entered, so a request arriving in the last HOLD cycle issues directly
    // and the pending slot is always empty while IDLE.
    always_comb begin
        state_nxt_s      = state_r;
        hold_nxt_s       = hold_cnt_r;
        issue_go_s       = 1'b0;
        pend_nxt_valid_s = mrg_valid_s;
        pend_nxt_man_s   = mrg_man_s;
        pend_nxt_cmd_s   = mrg_cmd_s;
        case (state_r)
            ST_IDLE: begin
                if (mrg_valid_s) begin
                    state_nxt_s = ST_ISSUE;
                    issue_go_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_HOLD;
                hold_nxt_s  = HOLD_W'(HOLDOFF);
            end
            ST_HOLD: begin
                hold_nxt_s = hold_cnt_r - HOLD_W'(1);
                // Counter about to reach zero: this is the last HOLD cycle.
                if (hold_cnt_r == HOLD_W'(1)) begin
                    if (mrg_valid_s) begin
                        state_nxt_s = ST_ISSUE;
                        issue_go_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                hold_nxt_s  = '0;
            end
        endcase
        if (issue_go_s || (state_r != ST_IDLE && state_r != ST_ISSUE && state_r != ST_HOLD)) begin
            pend_nxt_valid_s = 1'b0;
            pend_nxt_man_s   = 1'b0;
            pend_nxt_cmd_s   = CMD_NONE;
        end else begin
            pend_nxt_valid_s = mrg_valid_s;
            pend_nxt_man_s   = mrg_man_s;
            pend_nxt_cmd_s   = mrg_cmd_s;
        end
    end

    // State, hold counter and pending register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            hold_cnt_r   <= '0;
            pend_valid_r <= 1'b0;
            pend_man_r   <= 1'b0;
            pend_cmd_r   <= CMD_NONE;
        end else begin
            state_r      <= state_nxt_s;
            hold_cnt_r   <= hold_nxt_s;
            pend_valid_r <= pend_nxt_valid_s;
            pend_man_r   <= pend_nxt_man_s;
            pend_cmd_r   <= pend_nxt_cmd_s;
        end
    end

    // Registered outputs, decoded from the next state so that the command
    // pulse and the position update land on the edge that enters ISSUE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            up_r   <= 1'b0;
            down_r <= 1'b0;
            busy_r <= 1'b0;
            pos_r  <= 4'd0;
        end else begin
            up_r   <= issue_go_s & mrg_cmd_s[1];
            down_r <= issue_go_s & mrg_cmd_s[0];
            busy_r <= (state_nxt_s != ST_IDLE);
            if (issue_go_s) begin
                pos_r <= next_pos(pos_r, mrg_cmd_s);
            end else begin
                pos_r <= pos_r;
            end
        end
    end

    assign up   = up_r;
    assign down = down_r;
    assign busy = busy_r;
    assign pos  = pos_r;

endmodule

`default_nettype wire
